multi_counter: RTL and testbench

Parametrised multi-channel event counter: the next generation of the single-channel sub-counter. It provides configurable width and channel count, per-channel runtime up/down direction, one-shot or periodic (auto-reload) mode, arm/abort control, and sticky completion flags with an aggregated interrupt. It sits beside the testbench/control logic as the shared timing and event-count resource, with one independent counter per channel. All channels share one configuration port.

---
 rtl/multi_counter.sv | 155 +++++++++++++++
 tb/tb_multi_counter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_counter.sv
// rtl/multi_counter.sv - parametrised multi-channel event counter with sticky flags and irq
//
// Purpose: CHANNELS independent up/down counters sharing one configuration port.
// Each channel has a stop value, direction and one-shot/periodic mode, an IDLE/RUN
// state, a one-cycle done pulse, a sticky flag, and all flags OR into a registered irq.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   cfg_valid    configuration write request
//   cfg_ready    channel selected by cfg_chan is idle (combinational)
//   cfg_chan     target channel; values >= CHANNELS are accepted and dropped
//   cfg_stop     terminal value S
//   cfg_up       1 = count up, 0 = count down
//   cfg_periodic 1 = auto-reload, 0 = one-shot
//   arm          per-channel pulse, IDLE -> RUN
//   abort        per-channel pulse, RUN -> IDLE
//   start        per-channel count enable (level)
//   flag_clr     per-channel sticky flag clear
//   count        channel i at [i*WIDTH +: WIDTH]
//   busy         channel in RUN
//   done         one-cycle terminal pulse
//   flags        sticky done flags
//   irq          registered OR of flags
module multi_counter #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [CW-1:0]             cfg_chan,
    input  logic [WIDTH-1:0]          cfg_stop,
    input  logic                      cfg_up,
    input  logic                      cfg_periodic,
    input  logic [CHANNELS-1:0]       arm,
    input  logic [CHANNELS-1:0]       abort,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       flag_clr,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       flags,
    output logic                      irq
);

    logic [WIDTH-1:0]    cnt_q    [CHANNELS];
    logic [WIDTH-1:0]    stop_q   [CHANNELS];
    logic [WIDTH-1:0]    init_cur [CHANNELS];
    logic [WIDTH-1:0]    init_new;
    logic [CHANNELS-1:0] up_q;
    logic [CHANNELS-1:0] per_q;
    logic [CHANNELS-1:0] busy_q;
    logic [CHANNELS-1:0] settle_q;
    logic [CHANNELS-1:0] done_q;
    logic [CHANNELS-1:0] flags_q;
    logic                irq_q;

    logic [CHANNELS-1:0] sel;
    logic [CHANNELS-1:0] cfg_acc;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] term;
    logic [CHANNELS-1:0] go;

    always_comb begin
        cfg_ready = 1'b1;
        init_new  = cfg_up ? '0 : cfg_stop;
        sel       = '0;
        cfg_acc   = '0;
        tick      = '0;
        term      = '0;
        go        = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel[i] = (cfg_chan == CW'(i));
            if (sel[i]) begin
                cfg_ready = !busy_q[i];
            end
            cfg_acc[i]  = cfg_valid & sel[i] & !busy_q[i];
            init_cur[i] = up_q[i] ? '0 : stop_q[i];
            // The first enabled cycle after arm only settles the freshly loaded
            // value, so no count step happens until settle_q has been consumed.
            tick[i]     = busy_q[i] & !abort[i] & start[i] & !settle_q[i];
            // Compare before stepping: the counter never wraps, even for S = max.
            term[i]     = tick[i] & (up_q[i] ? (cnt_q[i] == stop_q[i])
                                             : (cnt_q[i] == '0));
            go[i]       = !busy_q[i] & arm[i] & !abort[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]    <= '0;
                stop_q[i]   <= '0;
                up_q[i]     <= 1'b1;
                per_q[i]    <= 1'b0;
                busy_q[i]   <= 1'b0;
                settle_q[i] <= 1'b0;
                done_q[i]   <= 1'b0;
                flags_q[i]  <= 1'b0;
            end
        end else begin
            irq_q <= |flags_q;
            for (int i = 0; i < CHANNELS; i++) begin
                done_q[i]  <= term[i];
                // A set in the same cycle as a clear wins.
                flags_q[i] <= term[i] | (flags_q[i] & !flag_clr[i]);

                if (cfg_acc[i]) begin
                    stop_q[i] <= cfg_stop;
                    up_q[i]   <= cfg_up;
                    per_q[i]  <= cfg_periodic;
                end

                if (busy_q[i]) begin
                    if (abort[i]) begin
                        busy_q[i]   <= 1'b0;
                        settle_q[i] <= 1'b0;
                        cnt_q[i]    <= init_cur[i];
                    end else if (term[i]) begin
                        if (per_q[i]) begin
                            cnt_q[i] <= init_cur[i];
                        end else begin
                            busy_q[i] <= 1'b0;
                        end
                    end else if (tick[i]) begin
                        cnt_q[i] <= up_q[i] ? cnt_q[i] + WIDTH'(1) : cnt_q[i] - WIDTH'(1);
                    end else if (start[i]) begin
                        settle_q[i] <= 1'b0;
                    end
                end else if (go[i]) begin
                    // A config accepted on the arm edge supplies the start value.
                    busy_q[i]   <= 1'b1;
                    settle_q[i] <= 1'b1;
                    cnt_q[i]    <= cfg_acc[i] ? init_new : init_cur[i];
                end else if (cfg_acc[i]) begin
                    cnt_q[i] <= init_new;
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_count
        assign count[g*WIDTH +: WIDTH] = cnt_q[g];
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign flags = flags_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_multi_counter.sv
// tb/tb_multi_counter.sv - directed-vector bench for multi_counter (WIDTH 8, CHANNELS 3)
module tb_multi_counter;

    localparam int W   = 8;
    localparam int C   = 3;
    localparam int CWB = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CWB-1:0] cfg_chan;
    logic [W-1:0]   cfg_stop;
    logic           cfg_up;
    logic           cfg_periodic;
    logic [C-1:0]   arm, abort, start, flag_clr;
    logic [C*W-1:0] count;
    logic [C-1:0]   busy, done, flags;
    logic           irq;

    int vectors     = 0;
    int miscompares = 0;

    multi_counter #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
        .cfg_stop(cfg_stop), .cfg_up(cfg_up), .cfg_periodic(cfg_periodic),
        .arm(arm), .abort(abort), .start(start), .flag_clr(flag_clr),
        .count(count), .busy(busy), .done(done), .flags(flags), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] cv(input int i);
        return count[i*W +: W];
    endfunction

    task automatic cfg_write(input int ch, input int s, input bit up, input bit per);
        cfg_valid    = 1'b1;
        cfg_chan     = CWB'(ch);
        cfg_stop     = W'(s);
        cfg_up       = up;
        cfg_periodic = per;
        step();
        cfg_valid = 1'b0;
    endtask

    bit st3 [12] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    int ec3 [12] = '{3, 2, 2, 2, 1, 0, 3, 2, 1, 0, 3, 2};
    bit ed3 [12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};

    initial begin
        int early;
        reset = 1'b1; cfg_valid = 1'b0; cfg_chan = '0; cfg_stop = '0;
        cfg_up = 1'b0; cfg_periodic = 1'b0;
        arm = '0; abort = '0; start = '0; flag_clr = '0;
        step(); step();
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", flags, 0);
        check("rst_irq", irq, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        reset = 1'b0;

        // Default config (S=0 up one-shot): done two cycles after arm.
        arm[0] = 1'b1; start[0] = 1'b1;
        step(); arm[0] = 1'b0;
        check("def_busy", busy[0], 1);
        step();
        check("def_done_early", done[0], 0);
        step();
        check("def_done", done[0], 1);
        check("def_count", cv(0), 0);
        check("def_busy_off", busy[0], 0);
        step();
        check("def_done_low", done[0], 0);
        check("def_flag", flags[0], 1);
        check("def_irq", irq, 1);
        start[0] = 1'b0; flag_clr[0] = 1'b1;
        step(); flag_clr[0] = 1'b0;
        check("clr_flag", flags[0], 0);
        step();
        check("clr_irq", irq, 0);

        // One-shot up, S=5 on channel 1.
        cfg_write(1, 5, 1'b1, 1'b0);
        check("os_cfg_count", cv(1), 0);
        arm[1] = 1'b1; start[1] = 1'b1;
        step(); arm[1] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("os_count_%0d", k), cv(1), k - 1);
            check($sformatf("os_nodone_%0d", k), done[1], 0);
        end
        step();
        check("os_done", done[1], 1);
        check("os_flag", flags[1], 1);
        check("os_busy", busy[1], 0);
        check("os_hold", cv(1), 5);
        check("os_irq_lag", irq, 0);
        step();
        check("os_irq", irq, 1);
        check("os_done_low", done[1], 0);
        check("os_hold2", cv(1), 5);
        start[1] = 1'b0; flag_clr[1] = 1'b1;
        step(); flag_clr[1] = 1'b0;

        // Periodic down, S=3 on channel 2, with a two-cycle start pause.
        cfg_write(2, 3, 1'b0, 1'b1);
        check("pd_cfg_count", cv(2), 3);
        arm[2] = 1'b1; start[2] = 1'b1;
        step(); arm[2] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            start[2] = st3[i];
            step();
            check($sformatf("pd_count_%0d", i), cv(2), ec3[i]);
            check($sformatf("pd_done_%0d", i), done[2], ed3[i]);
            check($sformatf("pd_busy_%0d", i), busy[2], 1);
        end
        start[2] = 1'b0; abort[2] = 1'b1;
        step(); abort[2] = 1'b0;
        check("pd_abort_busy", busy[2], 0);
        check("pd_abort_count", cv(2), 3);

        // Abort on the terminal cycle, then arm+abort together.
        cfg_write(0, 4, 1'b1, 1'b0);
        arm[0] = 1'b1; start[0] = 1'b1;
        step(); arm[0] = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        check("ab_at_stop", cv(0), 4);
        abort[0] = 1'b1;
        step(); abort[0] = 1'b0;
        check("ab_no_done", done[0], 0);
        check("ab_busy", busy[0], 0);
        check("ab_count", cv(0), 0);
        step();
        check("ab_no_done2", done[0], 0);
        check("ab_no_flag", flags[0], 0);
        arm[0] = 1'b1; abort[0] = 1'b1;
        step(); arm[0] = 1'b0; abort[0] = 1'b0;
        check("armabort_idle", busy[0], 0);
        start[0] = 1'b0;

        // Config handshake against a busy channel.
        cfg_write(1, 2, 1'b1, 1'b0);
        arm[1] = 1'b1; start[1] = 1'b1;
        step(); arm[1] = 1'b0;
        cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_stop = 8'd9; cfg_up = 1'b0; cfg_periodic = 1'b0;
        #1;
        check("hs_not_ready", cfg_ready, 0);
        step();
        check("hs_count_kept", cv(1), 0);
        step(); step(); step();
        check("hs_idle", busy[1], 0);
        check("hs_done", done[1], 1);
        check("hs_old_stop", cv(1), 2);
        check("hs_ready", cfg_ready, 1);
        step();
        check("hs_applied", cv(1), 9);
        cfg_valid = 1'b0; start[1] = 1'b0;
        cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_stop = 8'd77; cfg_up = 1'b0;
        #1;
        check("oob_ready", cfg_ready, 1);
        step(); cfg_valid = 1'b0;
        check("oob_ch0", cv(0), 0);
        check("oob_ch1", cv(1), 9);
        check("oob_ch2", cv(2), 3);
        flag_clr = '1;
        step(); flag_clr = '0;

        // S=255 up one-shot: no wrap, done 257 cycles after arm.
        cfg_write(0, 255, 1'b1, 1'b0);
        arm[0] = 1'b1; start[0] = 1'b1;
        step(); arm[0] = 1'b0;
        early = 0;
        for (int k = 1; k <= 256; k++) begin
            step();
            if (done[0]) early++;
            if (k == 128) check("max_mid", cv(0), 127);
        end
        check("max_no_early_done", early, 0);
        check("max_at_stop", cv(0), 255);
        step();
        check("max_done", done[0], 1);
        check("max_busy", busy[0], 0);
        check("max_no_wrap", cv(0), 255);
        start[0] = 1'b0;

        // S=0 periodic: done held high; flag set beats a simultaneous clear.
        cfg_write(2, 0, 1'b1, 1'b1);
        arm[2] = 1'b1; start[2] = 1'b1;
        step(); arm[2] = 1'b0;
        step();
        check("z_settle", done[2], 0);
        step();
        check("z_done_first", done[2], 1);
        flag_clr[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("z_done_%0d", k), done[2], 1);
            check($sformatf("z_flag_%0d", k), flags[2], 1);
            check($sformatf("z_count_%0d", k), cv(2), 0);
        end
        start[2] = 1'b0;
        step();
        check("z_stop_done", done[2], 0);
        check("z_clr_flag", flags[2], 0);
        check("z_still_busy", busy[2], 1);
        flag_clr[2] = 1'b0; abort[2] = 1'b1;
        step(); abort[2] = 1'b0;
        check("z_abort", busy[2], 0);

        // Reset mid-count, then the default config is back.
        arm[1] = 1'b1; start[1] = 1'b1;
        step(); arm[1] = 1'b0;
        step(); step();
        check("mid_count", cv(1), 8);
        reset = 1'b1;
        step(); reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_flags", flags, 0);
        check("mid_rst_irq", irq, 0);
        cfg_chan = 2'd1;
        #1;
        check("mid_rst_ready", cfg_ready, 1);
        arm[1] = 1'b1;
        step(); arm[1] = 1'b0;
        step(); step();
        check("mid_def_done", done[1], 1);
        check("mid_def_count", cv(1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
